// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: Wishbone master that turns register-access requests
// into I2C master core byte commands, polls SR and returns data/status.
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE = 16'd199,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [6:0] req_dev_i,
  input  logic [7:0] req_reg_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic [1:0] rsp_err_o,
  output logic       busy_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  output logic       m_we_o,
  output logic       m_stb_o,
  output logic       m_cyc_o,
  input  logic       m_ack_i
);

  localparam logic [2:0] A_PRL = 3'd0;
  localparam logic [2:0] A_PRH = 3'd1;
  localparam logic [2:0] A_CTR = 3'd2;
  localparam logic [2:0] A_TXR = 3'd3;
  localparam logic [2:0] A_CR  = 3'd4;

  localparam logic [1:0] E_OK   = 2'b00;
  localparam logic [1:0] E_NACK = 2'b01;
  localparam logic [1:0] E_AL   = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT);

  typedef enum logic [3:0] {
    S_INIT_PRL,
    S_INIT_PRH,
    S_INIT_CTR,
    S_IDLE,
    S_TXR,
    S_CR,
    S_POLL,
    S_RXR,
    S_STOP_CR,
    S_STOP_POLL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  err_q, err_d;
  logic        disc_q, disc_d;
  logic [31:0] tmr_q, tmr_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;

  logic [7:0]  txr_val;
  logic [7:0]  cr_val;
  logic        rd_step;
  logic        last_wr;
  logic        tmo;
  logic        sr_rxack;
  logic        sr_busy;
  logic        sr_al;
  logic        sr_tip;

  assign rd_step  = rw_q && (step_q == 2'd3);
  assign last_wr  = !rw_q && (step_q == 2'd2);
  assign tmo      = (tmr_q >= TMO_LIM);
  assign sr_rxack = m_dat_i[7];
  assign sr_busy  = m_dat_i[6];
  assign sr_al    = m_dat_i[5];
  assign sr_tip   = m_dat_i[1];

  // Per-step TXR and CR command bytes
  always_comb begin
    txr_val = 8'h00;
    cr_val  = 8'h00;
    unique case (step_q)
      2'd0: begin
        txr_val = {dev_q, 1'b0};
        cr_val  = 8'h90;
      end
      2'd1: begin
        txr_val = reg_q;
        cr_val  = 8'h10;
      end
      2'd2: begin
        txr_val = rw_q ? {dev_q, 1'b1} : wdata_q;
        cr_val  = rw_q ? 8'h90 : 8'h50;
      end
      default: begin
        txr_val = 8'h00;
        cr_val  = 8'h68;
      end
    endcase
  end

  // Next-state, bus command and bookkeeping logic
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    disc_d    = disc_q;
    tmr_d     = tmr_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      S_INIT_PRL: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = A_PRL;
          dat_d = PRESCALE[7:0];
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          state_d = S_INIT_PRH;
        end
      end
      S_INIT_PRH: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = A_PRH;
          dat_d = PRESCALE[15:8];
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          state_d = S_INIT_CTR;
        end
      end
      S_INIT_CTR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = A_CTR;
          dat_d = 8'h80;
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (req_valid_i) begin
          rw_d    = req_rw_i;
          dev_d   = req_dev_i;
          reg_d   = req_reg_i;
          wdata_d = req_wdata_i;
          step_d  = 2'd0;
          err_d   = E_OK;
          state_d = S_TXR;
        end
      end
      S_TXR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = A_TXR;
          dat_d = txr_val;
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          state_d = S_CR;
        end
      end
      S_CR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = A_CR;
          dat_d = cr_val;
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          disc_d  = 1'b1;
          tmr_d   = 32'd0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        tmr_d = tmr_q + 32'd1;
        if (!cyc_q) begin
          if (tmo) begin
            err_d   = E_TMO;
            state_d = S_STOP_CR;
          end else begin
            cyc_d = 1'b1;
            we_d  = 1'b0;
            adr_d = A_CR;
          end
        end else if (m_ack_i) begin
          cyc_d  = 1'b0;
          disc_d = 1'b0;
          if (!disc_q) begin
            if (sr_al) begin
              err_d   = E_AL;
              state_d = S_DONE;
            end else if (!sr_tip) begin
              if (sr_rxack && !rd_step) begin
                err_d   = E_NACK;
                state_d = S_STOP_CR;
              end else if (rd_step) begin
                state_d = S_RXR;
              end else if (last_wr) begin
                state_d = S_DONE;
              end else begin
                step_d  = step_q + 2'd1;
                state_d = (rw_q && step_q == 2'd2) ? S_CR : S_TXR;
              end
            end
          end
        end
      end
      S_RXR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = A_TXR;
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          rdata_d = m_dat_i;
          state_d = S_DONE;
        end
      end
      S_STOP_CR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = A_CR;
          dat_d = 8'h40;
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          disc_d  = 1'b1;
          tmr_d   = 32'd0;
          state_d = S_STOP_POLL;
        end
      end
      S_STOP_POLL: begin
        tmr_d = tmr_q + 32'd1;
        if (!cyc_q) begin
          if (tmo) begin
            state_d = S_DONE;
          end else begin
            cyc_d = 1'b1;
            we_d  = 1'b0;
            adr_d = A_CR;
          end
        end else if (m_ack_i) begin
          cyc_d  = 1'b0;
          disc_d = 1'b0;
          if (!disc_q && !sr_busy) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = S_INIT_PRL;
      end
    endcase

    if (state_d == S_DONE) begin
      rsp_err_d = err_d;
    end
  end

  // State and registered bus/response outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_INIT_PRL;
      step_q    <= 2'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wdata_q   <= 8'd0;
      err_q     <= E_OK;
      disc_q    <= 1'b0;
      tmr_q     <= 32'd0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 3'd0;
      dat_q     <= 8'd0;
      rdata_q   <= 8'd0;
      rsp_err_q <= E_OK;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      disc_q    <= disc_d;
      tmr_q     <= tmr_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign m_cyc_o     = cyc_q;
  assign m_stb_o     = cyc_q;
  assign m_we_o      = we_q;
  assign m_adr_o     = adr_q;
  assign m_dat_o     = dat_q;
  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = (state_q == S_DONE);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: directed bench with an I2C core model and
// scoreboards for core register writes and responses.
module tb_i2c_reg_sequencer;

  localparam int NONE = -9;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  logic [2:0] m_adr;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_we;
  logic       m_stb;
  logic       m_cyc;
  logic       m_ack;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_wr[$];
  logic [9:0]  exp_rsp[$];
  logic [10:0] wr_e;
  logic [9:0]  rsp_e;
  int cr_idx = 0;
  int rd_since = 0;
  int n_sr = 0;
  int n_rsp = 0;
  int cycles = 0;
  int t_rsp = 0;
  int t_acc = 0;
  logic sto_seen = 1'b0;
  int nack_idx = NONE;
  int al_idx = NONE;
  logic tip_stuck = 1'b0;
  logic [7:0] rx_byte = 8'h3C;
  logic ack_d = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.PRESCALE(16'd199), .TIMEOUT(50)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_rw_i(req_rw),
    .req_dev_i(req_dev),
    .req_reg_i(req_reg),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .busy_o(busy),
    .m_adr_o(m_adr),
    .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i),
    .m_we_o(m_we),
    .m_stb_o(m_stb),
    .m_cyc_o(m_cyc),
    .m_ack_i(m_ack)
  );

  // I2C core model: one-cycle ack, SR built from the test mode knobs
  always @(posedge clk) begin
    cycles <= cycles + 1;
    ack_d  <= m_ack && m_cyc;
    if (rst) begin
      m_ack   <= 1'b0;
      m_dat_i <= 8'h00;
    end else begin
      m_ack <= 1'b0;
      if (m_cyc && m_stb && !m_ack) begin
        m_ack <= 1'b1;
        if (!m_we && m_adr == 3'd4) begin
          m_dat_i <= {(cr_idx == nack_idx),
                      (sto_seen ? (rd_since < 2) : 1'b1),
                      (cr_idx == al_idx), 3'b000,
                      (tip_stuck || rd_since < 2), 1'b0};
          rd_since <= rd_since + 1;
          n_sr     <= n_sr + 1;
        end else if (!m_we && m_adr == 3'd3) begin
          m_dat_i <= rx_byte;
        end else if (!m_we) begin
          m_dat_i <= 8'h00;
        end else if (m_adr == 3'd4) begin
          cr_idx   <= cr_idx + 1;
          rd_since <= 0;
          if (m_dat_o[6]) sto_seen <= 1'b1;
        end
      end
      if (req_valid && req_ready) begin
        cr_idx   <= -1;
        sto_seen <= 1'b0;
      end
    end
  end

  // Write scoreboard: every acked core write must match the next expected one
  always @(posedge clk) begin
    if (!rst && m_cyc && m_stb && m_we && m_ack) begin
      n_cmp++;
      assert (exp_wr.size() != 0) else begin
        n_bad++;
        $error("FAIL wr_unexpected: got adr=%0d dat=%h want none", m_adr, m_dat_o);
      end
      if (exp_wr.size() != 0) begin
        wr_e = exp_wr.pop_front();
        n_cmp++;
        assert ({m_adr, m_dat_o} === wr_e) else begin
          n_bad++;
          $error("FAIL wr: got adr=%0d dat=%h want adr=%0d dat=%h",
                 m_adr, m_dat_o, wr_e[10:8], wr_e[7:0]);
        end
      end
    end
  end

  // Response scoreboard and bus rule (stb low in the cycle after ack)
  always @(negedge clk) begin
    if (!rst && ack_d) begin
      n_cmp++;
      assert (m_stb === 1'b0) else begin
        n_bad++;
        $error("FAIL stb_after_ack: got %b want 0", m_stb);
      end
    end
    if (!rst && rsp_valid) begin
      n_rsp++;
      t_rsp = cycles;
      n_cmp++;
      assert (exp_rsp.size() != 0) else begin
        n_bad++;
        $error("FAIL rsp_unexpected: got err=%b want none", rsp_err);
      end
      if (exp_rsp.size() != 0) begin
        rsp_e = exp_rsp.pop_front();
        n_cmp++;
        assert ({rsp_err, rsp_rdata} === rsp_e) else begin
          n_bad++;
          $error("FAIL rsp: got err=%b rdata=%h want err=%b rdata=%h",
                 rsp_err, rsp_rdata, rsp_e[9:8], rsp_e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic push_init();
    wr(3'd0, 8'hC7);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h80);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k;
    k = 0;
    while (!req_ready && k < budget) begin
      tick();
      k++;
    end
    check(tag, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic send(input logic rw, input logic [6:0] dev,
                      input logic [7:0] rg, input logic [7:0] wd);
    wait_ready("ready_before_req", 200);
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    @(posedge clk);
    t_acc = cycles;
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int k;
    int n0;
    k  = 0;
    n0 = n_rsp;
    while (n_rsp == n0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, {31'd0, n_rsp != n0}, 32'd1);
    check({tag, "_wr_left"}, exp_wr.size(), 32'd0);
    check({tag, "_rsp_left"}, exp_rsp.size(), 32'd0);
    tick();
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int n0;
    int k;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_dev   = 7'd0;
    req_reg   = 8'd0;
    req_wdata = 8'd0;
    repeat (3) tick();

    check("rst_cyc", {31'd0, m_cyc}, 32'd0);
    check("rst_stb", {31'd0, m_stb}, 32'd0);
    check("rst_we", {31'd0, m_we}, 32'd0);
    check("rst_adr", {29'd0, m_adr}, 32'd0);
    check("rst_dat", {24'd0, m_dat_o}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst_err", {30'd0, rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    push_init();
    rst = 1'b0;
    wait_ready("init_ready", 200);
    check("init_busy", {31'd0, busy}, 32'd0);
    check("init_wr_left", exp_wr.size(), 32'd0);

    wr(3'd3, 8'hA0); wr(3'd4, 8'h90);
    wr(3'd3, 8'h10); wr(3'd4, 8'h10);
    wr(3'd3, 8'hA5); wr(3'd4, 8'h50);
    exp_rsp.push_back({2'b00, 8'h00});
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    check("wr_busy", {31'd0, busy}, 32'd1);
    check("wr_ready_low", {31'd0, req_ready}, 32'd0);
    wait_rsp("write_ok", 500);

    wr(3'd3, 8'hA0); wr(3'd4, 8'h90);
    wr(3'd3, 8'h22); wr(3'd4, 8'h10);
    wr(3'd3, 8'hA1); wr(3'd4, 8'h90);
    wr(3'd4, 8'h68);
    exp_rsp.push_back({2'b00, 8'h3C});
    send(1'b1, 7'h50, 8'h22, 8'h00);
    wait_rsp("read_ok", 500);

    nack_idx = 0;
    wr(3'd3, 8'h42); wr(3'd4, 8'h90);
    wr(3'd4, 8'h40);
    exp_rsp.push_back({2'b01, 8'h3C});
    send(1'b0, 7'h21, 8'h05, 8'h77);
    wait_rsp("addr_nack", 500);
    nack_idx = NONE;

    al_idx = 1;
    wr(3'd3, 8'hA0); wr(3'd4, 8'h90);
    wr(3'd3, 8'h33); wr(3'd4, 8'h10);
    exp_rsp.push_back({2'b10, 8'h3C});
    send(1'b0, 7'h50, 8'h33, 8'h11);
    wait_rsp("arb_lost", 500);
    al_idx = NONE;

    tip_stuck = 1'b1;
    wr(3'd3, 8'hA0); wr(3'd4, 8'h90);
    wr(3'd4, 8'h40);
    exp_rsp.push_back({2'b11, 8'h3C});
    send(1'b0, 7'h50, 8'h44, 8'h22);
    wait_rsp("timeout", 500);
    check("timeout_dur", {31'd0, (t_rsp - t_acc) >= 55 && (t_rsp - t_acc) <= 110}, 32'd1);
    tip_stuck = 1'b0;

    wr(3'd3, 8'hA0); wr(3'd4, 8'h90);
    n0 = n_sr;
    send(1'b1, 7'h50, 8'h22, 8'h00);
    k = 0;
    while (n_sr == n0 && k < 200) begin
      tick();
      k++;
    end
    check("abort_reached_poll", {31'd0, n_sr != n0}, 32'd1);
    n0 = n_rsp;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cyc", {31'd0, m_cyc}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    check("abort_wr_left", exp_wr.size(), 32'd0);
    push_init();
    rst = 1'b0;
    wait_ready("abort_init_ready", 200);
    check("abort_no_rsp", n_rsp, n0);
    check("abort_init_wr_left", exp_wr.size(), 32'd0);

    wr(3'd3, 8'hA0); wr(3'd4, 8'h90);
    wr(3'd3, 8'h10); wr(3'd4, 8'h10);
    wr(3'd3, 8'h5A); wr(3'd4, 8'h50);
    exp_rsp.push_back({2'b00, 8'h00});
    send(1'b0, 7'h50, 8'h10, 8'h5A);
    wait_rsp("after_abort", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
